// File: rtl/leaper_movegen.sv
// Generates the destination moves of a knight or king on a square board.
// Each of the eight offsets is visited in order. On-board targets are read
// from the board memory, and every legal destination is streamed out with a
// valid/ready handshake.
module leaper_movegen #(
    parameter int COORD_W = 3,
    parameter int SQ_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] column,
    input  logic               color,
    output logic               busy,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_row,
    output logic [COORD_W-1:0] rd_col,
    input  logic [SQ_W-1:0]    rd_data,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic [COORD_W-1:0] mv_row,
    output logic [COORD_W-1:0] mv_col,
    output logic               mv_capture,
    output logic               done,
    output logic [7:0]         allow_mask
);

    localparam int TW = COORD_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CHECK,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic               mode_q, mode_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic               color_q, color_d;
    logic [7:0]         mask_q, mask_d;
    logic               cap_q, cap_d;

    logic signed [2:0]    dr, dc;
    logic signed [TW-1:0] tgt_row, tgt_col;
    logic                 off_board;
    logic                 legal;
    logic                 advance;
    logic                 unused_type_bits;

    // Offset table: (dr, dc) for the current piece kind and offset index.
    always_comb begin
        dr = 3'sd0;
        dc = 3'sd0;
        case ({mode_q, k_q})
            4'b0_000: begin dr = -3'sd2; dc = -3'sd1; end
            4'b0_001: begin dr = -3'sd2; dc =  3'sd1; end
            4'b0_010: begin dr = -3'sd1; dc =  3'sd2; end
            4'b0_011: begin dr =  3'sd1; dc =  3'sd2; end
            4'b0_100: begin dr =  3'sd2; dc =  3'sd1; end
            4'b0_101: begin dr =  3'sd2; dc = -3'sd1; end
            4'b0_110: begin dr =  3'sd1; dc = -3'sd2; end
            4'b0_111: begin dr = -3'sd1; dc = -3'sd2; end
            4'b1_000: begin dr = -3'sd1; dc =  3'sd0; end
            4'b1_001: begin dr = -3'sd1; dc =  3'sd1; end
            4'b1_010: begin dr =  3'sd0; dc =  3'sd1; end
            4'b1_011: begin dr =  3'sd1; dc =  3'sd1; end
            4'b1_100: begin dr =  3'sd1; dc =  3'sd0; end
            4'b1_101: begin dr =  3'sd1; dc = -3'sd1; end
            4'b1_110: begin dr =  3'sd0; dc = -3'sd1; end
            default:  begin dr = -3'sd1; dc = -3'sd1; end
        endcase
    end

    // The true target lies in [-2, 2^COORD_W+1]. In TW-bit two's complement,
    // both negative and too-large values have the top bit set.
    assign tgt_row   = $signed({1'b0, row_q}) + TW'(dr);
    assign tgt_col   = $signed({1'b0, col_q}) + TW'(dc);
    assign off_board = tgt_row[TW-1] | tgt_col[TW-1];

    // A destination is legal if it is empty or holds an opposing piece.
    assign legal            = ~rd_data[0] | (rd_data[1] != color_q);
    assign unused_type_bits = ^rd_data[SQ_W-1:2];

    // Scan state register, with synchronous reset that clears all state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            mode_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            color_q <= 1'b0;
            mask_q  <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            col_q   <= col_d;
            color_q <= color_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
        end
    end

    // Next-state logic and strobes for the issue/check/emit walk.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        color_d  = color_q;
        mask_d   = mask_q;
        cap_d    = cap_q;
        advance  = 1'b0;
        rd_en    = 1'b0;
        mv_valid = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    row_d   = row;
                    col_d   = column;
                    color_d = color;
                    mask_d  = '0;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (off_board) begin
                    mask_d[k_q] = 1'b0;
                    advance     = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (legal) begin
                    mask_d[k_q] = 1'b1;
                    cap_d       = rd_data[0];
                    state_d     = S_EMIT;
                end else begin
                    mask_d[k_q] = 1'b0;
                    advance     = 1'b1;
                end
            end
            S_EMIT: begin
                mv_valid = 1'b1;
                if (mv_ready) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (k_q == 3'd7) begin
                state_d = S_DONE;
            end else begin
                k_d     = k_q + 3'd1;
                state_d = S_ISSUE;
            end
        end
    end

    // Address and move outputs are zero unless their strobe is active.
    // The target is stable through CHECK and EMIT because k is not changing.
    assign busy       = (state_q != S_IDLE);
    assign rd_row     = rd_en ? tgt_row[COORD_W-1:0] : '0;
    assign rd_col     = rd_en ? tgt_col[COORD_W-1:0] : '0;
    assign mv_row     = mv_valid ? tgt_row[COORD_W-1:0] : '0;
    assign mv_col     = mv_valid ? tgt_col[COORD_W-1:0] : '0;
    assign mv_capture = mv_valid & cap_q;
    assign allow_mask = mask_q;

endmodule

// File: tb/tb_leaper_movegen.sv
// Self-checking bench for leaper_movegen: an 8x8 instance and a 16x16 instance
// share one board memory. Expected moves come from a plain offset-table model.
module tb_leaper_movegen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       color = 1'b0;
    logic       mv_ready = 1'b1;
    logic [3:0] in_row = '0;
    logic [3:0] in_col = '0;
    logic       sel = 1'b0;

    logic [4:0] board [0:15][0:15];

    // 8x8 instance
    logic       start8, busy8, rd_en8, mv_valid8, mv_capture8, done8;
    logic [2:0] rd_row8, rd_col8, mv_row8, mv_col8;
    logic [4:0] rd_data8 = '0;
    logic [7:0] mask8;
    // 16x16 instance
    logic       start16, busy16, rd_en16, mv_valid16, mv_capture16, done16;
    logic [3:0] rd_row16, rd_col16, mv_row16, mv_col16;
    logic [4:0] rd_data16 = '0;
    logic [7:0] mask16;

    assign start8  = start & ~sel;
    assign start16 = start & sel;

    leaper_movegen #(.COORD_W(3), .SQ_W(5)) dut (
        .clk(clk), .reset(reset), .start(start8), .mode(mode),
        .row(in_row[2:0]), .column(in_col[2:0]), .color(color),
        .busy(busy8), .rd_en(rd_en8), .rd_row(rd_row8), .rd_col(rd_col8),
        .rd_data(rd_data8), .mv_valid(mv_valid8), .mv_ready(mv_ready),
        .mv_row(mv_row8), .mv_col(mv_col8), .mv_capture(mv_capture8),
        .done(done8), .allow_mask(mask8)
    );

    leaper_movegen #(.COORD_W(4), .SQ_W(5)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .mode(mode),
        .row(in_row), .column(in_col), .color(color),
        .busy(busy16), .rd_en(rd_en16), .rd_row(rd_row16), .rd_col(rd_col16),
        .rd_data(rd_data16), .mv_valid(mv_valid16), .mv_ready(mv_ready),
        .mv_row(mv_row16), .mv_col(mv_col16), .mv_capture(mv_capture16),
        .done(done16), .allow_mask(mask16)
    );

    // Board memory: data valid one cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en8) rd_data8 <= board[rd_row8][rd_col8];
        else        rd_data8 <= 5'($urandom);
        if (rd_en16) rd_data16 <= board[rd_row16][rd_col16];
        else         rd_data16 <= 5'($urandom);
    end

    // Observation of whichever instance is selected.
    logic       o_busy, o_rd_en, o_mv_valid, o_mv_cap, o_done;
    logic [3:0] o_rd_row, o_rd_col, o_mv_row, o_mv_col;
    logic [7:0] o_mask;
    logic [28:0] o_all;
    assign o_busy     = sel ? busy16 : busy8;
    assign o_rd_en    = sel ? rd_en16 : rd_en8;
    assign o_mv_valid = sel ? mv_valid16 : mv_valid8;
    assign o_mv_cap   = sel ? mv_capture16 : mv_capture8;
    assign o_done     = sel ? done16 : done8;
    assign o_rd_row   = sel ? rd_row16 : {1'b0, rd_row8};
    assign o_rd_col   = sel ? rd_col16 : {1'b0, rd_col8};
    assign o_mv_row   = sel ? mv_row16 : {1'b0, mv_row8};
    assign o_mv_col   = sel ? mv_col16 : {1'b0, mv_col8};
    assign o_mask     = sel ? mask16 : mask8;
    assign o_all = {o_busy, o_rd_en, o_mv_valid, o_mv_cap, o_done, o_mask,
                    o_rd_row, o_rd_col, o_mv_row, o_mv_col};

    int errors = 0;
    int checks = 0;

    // Reference model
    int kdr [8] = '{-2, -2, -1, 1, 2, 2, 1, -1};
    int kdc [8] = '{-1, 1, 2, 2, 1, -1, -2, -2};
    int gdr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int gdc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int         exp_r[$];
    int         exp_c[$];
    bit         exp_cap[$];
    logic [7:0] exp_mask;
    int         exp_reads;

    task automatic model(input bit m, input int r, input int c, input bit colr, input int n);
        int tr, tc;
        logic [4:0] sq;
        exp_r.delete(); exp_c.delete(); exp_cap.delete();
        exp_mask = '0;
        exp_reads = 0;
        for (int k = 0; k < 8; k++) begin
            tr = r + (m ? gdr[k] : kdr[k]);
            tc = c + (m ? gdc[k] : kdc[k]);
            if (tr >= 0 && tr < n && tc >= 0 && tc < n) begin
                exp_reads++;
                sq = board[tr][tc];
                if (sq[0] == 1'b0 || sq[1] != colr) begin
                    exp_mask[k] = 1'b1;
                    exp_r.push_back(tr);
                    exp_c.push_back(tc);
                    exp_cap.push_back(sq[0]);
                end
            end
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                board[r][c] = '0;
    endtask

    task automatic random_board();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                board[r][c] = ($urandom_range(0, 1) == 1) ? 5'($urandom) | 5'd1 : 5'd0;
    endtask

    // rdy_mode: 0 always ready, 1 random ready, 2 stall first emit 5 cycles.
    task automatic run_scan(input bit s, input bit m, input int r, input int c,
                            input bit colr, input int rdy_mode, input bit noisy,
                            output int done_cyc);
        int gr[$];
        int gc[$];
        bit gcap[$];
        int reads = 0, dones = 0, hold_err = 0, stall_left = 5;
        int late_done = 0, busy_after = 0;
        bit pv = 1'b0, pr = 1'b0, pcap = 1'b0;
        logic [3:0] prow = '0, pcol = '0;
        model(m, r, c, colr, s ? 16 : 8);
        @(negedge clk);
        sel = s; mode = m; in_row = 4'(r); in_col = 4'(c); color = colr;
        start = 1'b1; mv_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            if (pv && !pr) begin
                if (!(o_mv_valid && o_mv_row == prow && o_mv_col == pcol && o_mv_cap == pcap))
                    hold_err++;
            end
            if (o_rd_en) reads++;
            if (o_rd_en && o_mv_valid) hold_err++;
            if (o_done) begin dones++; done_cyc = cyc; end
            case (rdy_mode)
                1: mv_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (o_mv_valid && gr.size() == 0 && stall_left > 0) begin
                        mv_ready = 1'b0;
                        stall_left--;
                    end else mv_ready = 1'b1;
                end
                default: mv_ready = 1'b1;
            endcase
            if (o_mv_valid && mv_ready) begin
                gr.push_back(int'(o_mv_row));
                gc.push_back(int'(o_mv_col));
                gcap.push_back(o_mv_cap);
            end
            pv = o_mv_valid; pr = mv_ready; prow = o_mv_row; pcol = o_mv_col; pcap = o_mv_cap;
            if (noisy && done_cyc < 0) begin
                start = 1'($urandom); mode = 1'($urandom); color = 1'($urandom);
                in_row = 4'($urandom); in_col = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done_cyc < 0) @(negedge clk);
        end
        start = 1'b0; mv_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (o_done) late_done++;
            if (o_busy) busy_after++;
        end
        $display("scan w=%0d mode=%0d org=(%0d,%0d) color=%0d moves=%0d mask=%b done_cyc=%0d",
                 s ? 16 : 8, m, r, c, colr, gr.size(), o_mask, done_cyc);
        checks++;
        if (done_cyc < 0) begin errors++; $display("FAIL timeout: no done within budget"); end
        checks++;
        if (gr.size() != exp_r.size()) begin
            errors++;
            $display("FAIL move_count: got %0d expected %0d", gr.size(), exp_r.size());
        end else begin
            for (int i = 0; i < gr.size(); i++) begin
                checks++;
                if (gr[i] != exp_r[i] || gc[i] != exp_c[i] || gcap[i] != exp_cap[i]) begin
                    errors++;
                    $display("FAIL move%0d: got (%0d,%0d,cap=%0d) expected (%0d,%0d,cap=%0d)",
                             i, gr[i], gc[i], gcap[i], exp_r[i], exp_c[i], exp_cap[i]);
                end
            end
        end
        checks++;
        if (o_mask !== exp_mask) begin
            errors++; $display("FAIL allow_mask: got %b expected %b", o_mask, exp_mask);
        end
        checks++;
        if (dones + late_done != 1) begin
            errors++; $display("FAIL done_count: got %0d expected 1", dones + late_done);
        end
        checks++;
        if (reads != exp_reads) begin
            errors++; $display("FAIL read_count: got %0d expected %0d", reads, exp_reads);
        end
        checks++;
        if (hold_err != 0) begin
            errors++; $display("FAIL emit_hold: got %0d violations expected 0", hold_err);
        end
        checks++;
        if (busy_after != 0) begin
            errors++; $display("FAIL idle_after: busy in %0d cycles expected 0", busy_after);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; sel = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_all !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", o_all);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL start_with_reset: busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_knight_corner();
        int dc;
        clear_board();
        run_scan(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, dc);
        checks++;
        if (dc != 13) begin errors++; $display("FAIL knight_latency: got %0d expected 13", dc); end
        checks++;
        if (o_mask !== 8'b0001_1000) begin
            errors++; $display("FAIL knight_corner_mask: got %b expected 00011000", o_mask);
        end
    endtask

    task automatic test_king_corner();
        int dc;
        clear_board();
        board[6][6] = 5'b001_01;
        board[6][7] = 5'b010_11;
        run_scan(1'b0, 1'b1, 7, 7, 1'b0, 0, 1'b0, dc);
        checks++;
        if (o_mask !== 8'b0100_0001) begin
            errors++; $display("FAIL king_corner_mask: got %b expected 01000001", o_mask);
        end
    endtask

    task automatic test_stall();
        int dc;
        clear_board();
        run_scan(1'b0, 1'b0, 4, 4, 1'b1, 2, 1'b0, dc);
    endtask

    task automatic test_random();
        int dc;
        for (int i = 0; i < 30; i++) begin
            random_board();
            run_scan(1'b0, 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                     1'($urandom), 1, 1'b0, dc);
        end
    endtask

    task automatic test_busy_start();
        int dc;
        for (int i = 0; i < 4; i++) begin
            random_board();
            run_scan(1'b0, 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                     1'($urandom), 0, 1'b1, dc);
        end
    endtask

    task automatic test_reset_mid();
        int xfers = 0, dc, stray = 0;
        bit hit = 1'b0;
        clear_board();
        @(negedge clk);
        sel = 1'b0; mode = 1'b0; in_row = 4'd4; in_col = 4'd4; color = 1'b0;
        start = 1'b1; mv_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (o_mv_valid) begin
                if (xfers == 1) begin
                    hit = 1'b1; reset = 1'b1; mv_ready = 1'b0;
                end else xfers++;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_reach: second emit not seen"); end
        checks++;
        if (o_all !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h expected 0", o_all);
        end
        reset = 1'b0; mv_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (o_done || o_busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", stray);
        end
        run_scan(1'b0, 1'b0, 4, 4, 1'b0, 0, 1'b0, dc);
    endtask

    task automatic test_wide();
        int dc;
        clear_board();
        run_scan(1'b1, 1'b0, 15, 15, 1'b0, 0, 1'b0, dc);
        checks++;
        if (o_mask !== 8'b1000_0001) begin
            errors++; $display("FAIL wide_corner_mask: got %b expected 10000001", o_mask);
        end
        random_board();
        run_scan(1'b1, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, 1, 1'b0, dc);
        sel = 1'b0;
    endtask

    initial begin
        clear_board();
        test_reset();
        test_knight_corner();
        test_king_corner();
        test_stall();
        test_random();
        test_busy_start();
        test_reset_mid();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
